// File: rtl/apple_kbd_ctrl.sv
`timescale 1ns/1ps
// apple_kbd_ctrl: turns NIOS keycode PIO writes into Apple II+ KBD/KBDSTRB soft switches,
// with a press FIFO and typematic auto-repeat.
// Ports: clk, reset_n (async, active-low); keycode (PIO byte, bit 7 ignored);
//        cpu_addr/cpu_acc (6502 bus, cpu_acc = completed access pulse);
//        cpu_dout/cpu_dout_en (read data for $C000-$C01F); akd (any key down);
//        fifo_count (queue occupancy); overflow (one-cycle pulse on a dropped push).
module apple_kbd_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_W        = 25
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    keycode,
    input  logic [15:0]                   cpu_addr,
    input  logic                          cpu_acc,
    output logic [7:0]                    cpu_dout,
    output logic                          cpu_dout_en,
    output logic                          akd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE - 1);

    logic [6:0]       kc_q;
    logic [6:0]       kc_prev;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    logic [6:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    logic [6:0]       latch;
    logic             strobe;

    logic press;
    logic rep_due;
    logic rep_push;
    logic push;
    logic empty;
    logic full;
    logic pop;
    logic wr_ok;
    logic strobe_clr;
    logic io_sel;

    assign press    = (kc_q != kc_prev) && (kc_q != 7'd0);
    // A press restarts the counter, so it always wins over a repeat.
    assign rep_due  = ((state == S_DELAY) || (state == S_REPEAT)) &&
                      (cnt == '0) && (kc_q != 7'd0) && !press;
    // Repeats only go out when the CPU has taken everything so far.
    assign rep_push = rep_due && empty && !strobe;
    assign push     = press || rep_push;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign pop      = !strobe && !empty;
    assign wr_ok    = push && !full;

    assign strobe_clr = cpu_acc && (cpu_addr[15:4] == 12'hC01);

    assign akd        = (kc_q != 7'd0);
    assign fifo_count = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc_q    <= '0;
            kc_prev <= '0;
        end else begin
            kc_q    <= keycode[6:0];
            kc_prev <= kc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (kc_q == 7'd0) begin
            state <= S_IDLE;
        end else if (press) begin
            state <= S_DELAY;
            cnt   <= DELAY_LD;
        end else begin
            case (state)
                S_DELAY: begin
                    if (cnt == '0) begin
                        state <= S_REPEAT;
                        cnt   <= RATE_LD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_REPEAT: begin
                    if (cnt == '0) cnt <= RATE_LD;
                    else           cnt <= cnt - CNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full;
            if (wr_ok) begin
                mem[wr_ptr] <= kc_q;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Load needs strobe low and clear needs strobe high, so they never collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latch  <= '0;
            strobe <= 1'b0;
        end else if (pop) begin
            latch  <= mem[rd_ptr];
            strobe <= 1'b1;
        end else if (strobe_clr) begin
            strobe <= 1'b0;
        end
    end

    assign io_sel      = (cpu_addr[15:5] == 11'h600);
    assign cpu_dout_en = io_sel;

    always_comb begin
        cpu_dout = 8'h00;
        if (io_sel) begin
            if (cpu_addr[4]) cpu_dout = {akd, latch};
            else             cpu_dout = {strobe, latch};
        end
    end

endmodule

// File: doc/apple_kbd_ctrl.md
Name: apple_kbd_ctrl

Overview:
- Sequences keyboard keycodes written by the NIOS into the 8-bit keycode PIO and presents them to the 6502 as the Apple II+ keyboard soft switches: KBD at $C000-$C00F, KBDSTRB clear at $C010-$C01F.
- Detects new key presses and queues them in a small FIFO.
- Generates typematic auto-repeat.
- Holds the latched key with the strobe bit until the CPU clears it.

Parameters:
- FIFO_DEPTH, 4: keycode queue entries; power of 2, minimum 2.
- REPEAT_DELAY, 25000000: cycles from press to first repeat (500 ms at 50 MHz).
- REPEAT_RATE, 5000000: cycles between subsequent repeats (100 ms).
- CNT_W, 25: width of the repeat counter; must hold max(REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk, input, 1: system clock. Same domain as the PIO and the CPU bus.
- reset_n, input, 1: asynchronous, active-low reset.
- keycode, input, 8: ASCII byte from the PIO out_port. Bits 6:0 = key; 0x00 = no key held. Bit 7 is ignored.
- cpu_addr, input, 16: 6502 address bus.
- cpu_acc, input, 1: one-cycle pulse marking a completed bus access (read or write) at cpu_addr.
- cpu_dout, output, 8: read data for the keyboard I/O range.
- cpu_dout_en, output, 1: high when cpu_addr is in $C000-$C01F.
- akd, output, 1: any key down (registered keycode[6:0] != 0).
- fifo_count, output, log2(FIFO_DEPTH)+1: current queue occupancy.
- overflow, output, 1: one-cycle pulse when a push is dropped because the FIFO is full.

Behaviour:
- Reset: all registers cleared. cpu_dout=0, akd=0, fifo_count=0, overflow=0, strobe=0, latch=0, FSM=IDLE.
- Input stage: kc_q <= keycode[6:0] every cycle; kc_prev <= kc_q.
- Press event: kc_q != kc_prev and kc_q != 0. A direct change from one key to another counts as a press.
- Repeat FSM, 3 states:
  - IDLE -> DELAY on press event; cnt <= REPEAT_DELAY-1.
  - DELAY: cnt decrements. At cnt==0, issue a repeat push of kc_q; go to REPEAT, cnt <= REPEAT_RATE-1.
  - REPEAT: cnt decrements. At cnt==0, issue a repeat push; cnt <= REPEAT_RATE-1.
  - Any state: kc_q==0 -> IDLE. A press event in DELAY or REPEAT restarts DELAY with the new key.
  - A repeat push is suppressed when the FIFO is non-empty or strobe==1; the counter still reloads.
- FIFO:
  - Press push and repeat push never coincide (press has priority; a press restarts the counter).
  - Push while full: data dropped, overflow pulses for 1 cycle, contents unchanged.
  - Simultaneous push and pop when full: the pop proceeds; the push is dropped and overflow pulses.
  - Simultaneous push and pop when empty: the push is stored; no pop occurs, because the FIFO was empty.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Latch/strobe:
  - When strobe==0 and the FIFO is non-empty: pop, latch <= head, strobe <= 1 on the same edge.
  - Latency from keycode change to strobe visible, with empty FIFO and strobe clear: high after the 3rd rising edge.
  - Clear: cpu_acc with cpu_addr in $C010-$C01F -> strobe <= 0 at the next edge. latch[6:0] is retained.
  - Clear while strobe==0: no effect.
  - The next FIFO entry loads no earlier than the cycle after the clear. Clear and load never occur on the same edge.
- Read mux, combinational:
  - $C000-$C00F: cpu_dout = {strobe, latch}.
  - $C010-$C01F: cpu_dout = {akd, latch}.
  - Otherwise: cpu_dout = 0.
  - cpu_dout_en follows the address decode only, independent of cpu_acc.
- Reset asserted mid-operation: FIFO flushed, strobe dropped, FSM=IDLE immediately (asynchronous).

Test Plan:
- Reset, then keycode=0x41 -> strobe high after 3rd edge; read $C000 returns 0xC1; akd=1. Access $C010 -> next read of $C000 returns 0x41.
- keycode 0x41 -> 0x42 -> 0x43 held 1 cycle each, no CPU clears -> 0xC1 shown; after each clear, 0xC2 then 0xC3; fifo_count peaks at 2.
- FIFO_DEPTH=4, six distinct presses with no clears -> 1 latched + 4 queued; overflow pulses exactly once; the sixth key is never delivered.
- REPEAT_DELAY=10, REPEAT_RATE=4, hold 0x20, clearing the strobe promptly after each delivery -> second delivery ~10 cycles after the first press push; later deliveries every 4 cycles while held. Release -> no further deliveries.
- Hold a key, never clear the strobe -> no repeat pushes; fifo_count stays 0.
- Assert reset_n low with 3 entries queued and strobe set -> cpu_dout at $C000 reads 0 and fifo_count=0 immediately. After release, no stale keys appear.
